// File: rtl/psum_row_pack.sv
// Collects psum words from the row convolver into row-wide banks and presents whole rows downstream.
// Define PSUM_ROW_PACK_DBUF_EN for two ping-pong banks; otherwise a single bank is used.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef CHANNEL_DEPTH
`define CHANNEL_DEPTH 4
`endif
`ifndef LENPSUM
`define LENPSUM 4
`endif
`ifndef C_LOG_2
`define C_LOG_2(n) $clog2(n)
`endif

module psum_row_pack #(
    parameter int PSUM_WIDTH = `DATA_WIDTH*2 + `C_LOG_2(`CHANNEL_DEPTH) + 2,
    parameter int LENPSUM    = `LENPSUM
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            CNVPRW_Val,
    input  logic [PSUM_WIDTH-1:0]           CNVPRW_Psum,
    input  logic                            CNVPRW_FnhRow,
    output logic                            PRWCNV_Rdy,
    output logic                            PRWOUT_Val,
    input  logic                            OUTPRW_Rdy,
    output logic [PSUM_WIDTH*LENPSUM-1:0]   PRWOUT_Psum,
    output logic [$clog2(LENPSUM):0]        PRWOUT_Len
);

    localparam int AW = (LENPSUM > 1) ? $clog2(LENPSUM) : 1;
    localparam int LW = $clog2(LENPSUM) + 1;
    localparam int RW = PSUM_WIDTH * LENPSUM;
    localparam logic [AW-1:0] LAST = AW'(LENPSUM - 1);

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_st_e;

    // Two bank slots always exist; without double buffering the pointers stay at 0
    // and the second slot holds its reset value, so synthesis removes it.
    bank_st_e        st_q   [2];
    bank_st_e        st_d   [2];
    logic [RW-1:0]   mem_q  [2];
    logic [RW-1:0]   mem_d  [2];
    logic [LW-1:0]   len_q  [2];
    logic [LW-1:0]   len_d  [2];
    logic [AW-1:0]   addr_q, addr_d;
    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic            accept, close, xfer;

    assign PRWCNV_Rdy  = (st_q[wptr_q] == FREE);
    assign PRWOUT_Val  = (st_q[rptr_q] == FULL);
    assign PRWOUT_Psum = PRWOUT_Val ? mem_q[rptr_q] : '0;
    assign PRWOUT_Len  = len_q[rptr_q];

    assign accept = CNVPRW_Val && PRWCNV_Rdy;
    assign close  = accept && (CNVPRW_FnhRow || (addr_q == LAST));
    assign xfer   = PRWOUT_Val && OUTPRW_Rdy;

    always_comb begin
        st_d   = st_q;
        mem_d  = mem_q;
        len_d  = len_q;
        addr_d = addr_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;

        // A transfer needs a FULL bank and a write needs a FREE one, so both
        // can act in the same edge without ever touching the same bank.
        if (xfer) begin
            st_d[rptr_q]  = FREE;
            mem_d[rptr_q] = '0;
            len_d[rptr_q] = '0;
`ifdef PSUM_ROW_PACK_DBUF_EN
            rptr_d = ~rptr_q;
`else
            rptr_d = 1'b0;
`endif
        end

        if (accept) begin
            mem_d[wptr_q][PSUM_WIDTH*addr_q +: PSUM_WIDTH] = CNVPRW_Psum;
            addr_d = addr_q + AW'(1);
            if (close) begin
                st_d[wptr_q]  = FULL;
                len_d[wptr_q] = LW'(addr_q) + LW'(1);
                addr_d        = '0;
`ifdef PSUM_ROW_PACK_DBUF_EN
                wptr_d = ~wptr_q;
`else
                wptr_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                st_q[b]  <= FREE;
                mem_q[b] <= '0;
                len_q[b] <= '0;
            end
            addr_q <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                st_q[b]  <= st_d[b];
                mem_q[b] <= mem_d[b];
                len_q[b] <= len_d[b];
            end
            addr_q <= addr_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: tb/tb_psum_row_pack.sv
// Bench for psum_row_pack: queue-of-rows reference model compared every cycle, plus literal row checks.
module tb_psum_row_pack;

    localparam int PW  = 20;
    localparam int LEN = 4;
    localparam int RW  = PW * LEN;
`ifdef PSUM_ROW_PACK_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cval  = 1'b0;
    logic [PW-1:0] cdata = '0;
    logic          cfnh  = 1'b0;
    logic          prdy;
    logic          oval;
    logic          ordy  = 1'b0;
    logic [RW-1:0] opsum;
    logic [2:0]    olen;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    psum_row_pack #(
        .PSUM_WIDTH (PW),
        .LENPSUM    (LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CNVPRW_Val    (cval),
        .CNVPRW_Psum   (cdata),
        .CNVPRW_FnhRow (cfnh),
        .PRWCNV_Rdy    (prdy),
        .PRWOUT_Val    (oval),
        .OUTPRW_Rdy    (ordy),
        .PRWOUT_Psum   (opsum),
        .PRWOUT_Len    (olen)
    );

    task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: closed rows waiting downstream, plus the row being gathered.
    logic [RW-1:0] mq_psum[$];
    int            mq_len[$];
    logic [RW-1:0] cur = '0;
    int            cnt = 0;

    initial begin
        bit acc, xf;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq_psum.delete();
                mq_len.delete();
                cur = '0;
                cnt = 0;
            end else begin
                acc = cval && (mq_len.size() < NB);
                xf  = (mq_len.size() > 0) && ordy;
                if (xf) begin
                    void'(mq_psum.pop_front());
                    void'(mq_len.pop_front());
                end
                if (acc) begin
                    cur[PW*cnt +: PW] = cdata;
                    cnt++;
                    if (cfnh || cnt == LEN) begin
                        mq_psum.push_back(cur);
                        mq_len.push_back(cnt);
                        cur = '0;
                        cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("rdy", prdy, mq_len.size() < NB);
                chk("val", oval, mq_len.size() > 0);
                if (mq_len.size() > 0) begin
                    chk("psum", opsum, mq_psum[0]);
                    chk("len", olen, mq_len[0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Hold one word on the input until the DUT takes it; returns 1 time unit after the accepting edge.
    task automatic send(input logic [PW-1:0] w, input logic f);
        bit r;
        int n;
        n    = 0;
        cval = 1'b1;
        cdata = w;
        cfnh = f;
        do begin
            @(negedge clk);
            r = prdy;
            @(posedge clk);
            #1;
            n++;
        end while (!r && n < 50);
        if (!r) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h not accepted in 50 cycles", w);
        end
        cval = 1'b0;
        cfnh = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_val", oval, 1'b0);
        chk("rst_psum", opsum, '0);
        chk("rst_len", olen, 3'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rdy", prdy, 1'b1);

        // Full row back to back
        ordy = 1'b1;
        send(20'd1, 1'b0);
        send(20'd2, 1'b0);
        send(20'd3, 1'b0);
        send(20'd4, 1'b0);
        chk("r1_val", oval, 1'b1);
        chk("r1_psum", opsum, 80'h00004_00003_00002_00001);
        chk("r1_len", olen, 3'd4);

        // Short row closed by FnhRow
        send(20'd7, 1'b0);
        send(20'd9, 1'b1);
        chk("r2_val", oval, 1'b1);
        chk("r2_psum", opsum, 80'h00000_00000_00009_00007);
        chk("r2_len", olen, 3'd2);

        // FnhRow on the first word, max value
        send(20'hFFFFF, 1'b1);
        chk("r3_psum", opsum, 80'h00000_00000_00000_FFFFF);
        chk("r3_slot0", opsum[PW-1:0], 20'hFFFFF);
        chk("r3_len", olen, 3'd1);
        repeat (2) @(posedge clk);
        #1;

        // Back-pressure: two full rows with the consumer stalled
        ordy = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send((i < 4) ? PW'(32'h11 + i) : PW'(32'h21 + i - 4), 1'b0);
            end
            begin
                repeat (12) @(posedge clk);
                #2;
                chk("bp_rdy", prdy, 1'b0);
                chk("bp_val", oval, 1'b1);
                chk("bp_psum", opsum, 80'h00014_00013_00012_00011);
                ordy = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Reset with a pending FULL bank and a partial row
        ordy = 1'b0;
        send(20'h31, 1'b0);
        send(20'h32, 1'b0);
        send(20'h33, 1'b0);
        send(20'h34, 1'b0);
`ifdef PSUM_ROW_PACK_DBUF_EN
        send(20'h41, 1'b0);
        send(20'h42, 1'b0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_val", oval, 1'b0);
        chk("mr_psum", opsum, '0);
        chk("mr_len", olen, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mr_idle_val", oval, 1'b0);
        chk("mr_rdy", prdy, 1'b1);
        ordy = 1'b1;
        send(20'd5, 1'b0);
        send(20'd6, 1'b0);
        send(20'd7, 1'b0);
        send(20'd8, 1'b0);
        chk("mr_psum_new", opsum, 80'h00008_00007_00006_00005);
        chk("mr_len_new", olen, 3'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("mr_drained", oval, 1'b0);

        // Randomized traffic, with alternating light and heavy back-pressure
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            cval  = ($urandom_range(0, 3) != 0);
            cdata = PW'($urandom);
            cfnh  = ($urandom_range(0, 3) == 0);
            ordy  = (c % 200 < 100) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #1;
        cval = 1'b0;
        cfnh = 1'b0;
        ordy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("final_val", oval, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_row_pack.md
PSUM_ROW_PACK -- requirements
Module: psum_row_pack

Interface
REQ-001 SHALL have parameter PSUM_WIDTH, default (`DATA_WIDTH*2 + `C_LOG_2(`CHANNEL_DEPTH) + 2), psum word width.
REQ-002 SHALL have parameter LENPSUM, default `LENPSUM, words per row.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port CNVPRW_Val  input  1  psum word valid from the row convolver.
REQ-006 SHALL have port CNVPRW_Psum  input  PSUM_WIDTH  psum word.
REQ-007 SHALL have port CNVPRW_FnhRow  input  1  qualifies the current word as last of row; ignored unless CNVPRW_Val is high.
REQ-008 SHALL have port PRWCNV_Rdy  output  1  word accepted when Val&&Rdy.
REQ-009 SHALL have port PRWOUT_Val  output  1  packed row valid.
REQ-010 SHALL have port OUTPRW_Rdy  input  1  downstream takes row when Val&&Rdy.
REQ-011 SHALL have port PRWOUT_Psum  output  PSUM_WIDTH*LENPSUM  packed row; slot k at [PSUM_WIDTH*k +: PSUM_WIDTH], i.e. directly usable as a next-row CNVIN_Psum.
REQ-012 SHALL have port PRWOUT_Len  output  C_LOG_2(LENPSUM)+1  valid word count of presented row, 1..LENPSUM.

Function
REQ-013 SHALL hold per-bank state FREE/FULL; write bank is the bank at write pointer, read bank the bank at read pointer.
REQ-014 PRWCNV_Rdy SHALL equal "write bank FREE", driven from registered state only; no combinational path from OUTPRW_Rdy.
REQ-015 An accepted word SHALL be stored in write-bank slot Addr, then Addr increments.
REQ-016 Row SHALL close on an accepted word with CNVPRW_FnhRow=1, or on the accepted word at Addr==LENPSUM-1, whichever comes first.
REQ-017 On close: write bank -> FULL, its length = Addr+1, Addr -> 0, write pointer toggles (when double-buffered), all in the same edge.
REQ-018 Closing word accepted at edge t SHALL make PRWOUT_Val high after edge t (1-cycle latency).
REQ-019 PRWOUT_Val SHALL equal "read bank FULL"; PRWOUT_Psum/PRWOUT_Len SHALL stay stable while Val&&!Rdy.
REQ-020 On transfer, read bank -> FREE with all slots zeroed, read pointer toggles; slots beyond Len SHALL read as zero.
REQ-021 Same-edge close into one bank and transfer from the other SHALL both take effect.
REQ-022 Words offered while Rdy=0 SHALL not be stored; Addr SHALL not change.
REQ-023 FnhRow on first word (Addr==0) SHALL produce a row of Len=1.
REQ-024 Row order at output SHALL equal closing order; no row is lost or duplicated.

Reset
REQ-025 On rst_n low, asynchronously: all banks FREE and zero, Addr=0, pointers=0, PRWCNV_Rdy=1 after release, PRWOUT_Val=0, PRWOUT_Psum=0, PRWOUT_Len=0.
REQ-026 Reset mid-row or with a FULL bank pending SHALL discard that data; no row emitted after release until a new close.

Configuration
REQ-027 Macro PSUM_ROW_PACK_DBUF_EN defined: two banks, ping-pong; filling continues while other bank awaits the consumer.
REQ-028 Macro undefined: one bank, pointers fixed at 0; PRWCNV_Rdy low from close until the edge after transfer (one-cycle bubble minimum).

Verification (bench: LENPSUM=4, PSUM_WIDTH=20)
REQ-029 Reset, then words 1,2,3,4 back-to-back, OUTPRW_Rdy=1 -> Val one cycle after 4th, Psum=0x00004_00003_00002_00001, Len=4.
REQ-030 Words 7,9 with FnhRow on 9 -> Psum=0x00000_00000_00009_00007, Len=2; next row begins at slot 0.
REQ-031 DBUF_EN, OUTPRW_Rdy=0, two full rows streamed -> Rdy drops after 8th word; row1 held stable; raising OUTPRW_Rdy emits row1 then row2 in order, Rdy returns 1 after row1 transfer.
REQ-032 DBUF undefined, same stimulus -> Rdy low from 4th word until edge after row1 transfer; 5th word held off, no data lost.
REQ-033 Single word 0xFFFFF with FnhRow -> Len=1, slot0=0xFFFFF, slots 1-3 zero.
REQ-034 rst_n pulsed low mid-row after 2 words and with one FULL bank -> Val=0 immediately; next row 5,6,7,8 emits Psum=0x00008_00007_00006_00005 only.
